adc_conversion_sequencer: RTL and testbench

Sequences the SAR-ADC digital core (adc_core_digital) for single-shot or periodic conversions. It shares the core's clock domain (clk_dig_in), holds the core in reset between conversions and presents stable configuration words. It also watches for conversion completion with a timeout, and buffers results in a small FIFO with a valid/ready output handshake toward the host/register interface.

---
 rtl/adc_conversion_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_adc_conversion_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conversion_sequencer.sv
// adc_conversion_sequencer
//   Sequences the SAR-ADC digital core (adc_core_digital) for single-shot or
//   periodic conversions. Shares the core clock, holds the core in reset
//   between conversions, presents latched configuration words, aborts a
//   conversion that never completes, and buffers results in a small FIFO with
//   a valid/ready handshake toward the host.
//
// Ports
//   clk, rst_n            clock (core clk_dig_in net), synchronous active-low reset
//   start_single_in       pulse: request one conversion (IDLE only)
//   continuous_in         level: free-running conversions while high
//   stop_in               pulse: end continuous operation
//   interval_in           idle cycles between continuous conversions
//   avg_control_in        averaging setting, latched at ARM
//   osr_mode_in           oversampling mode, latched at ARM
//   clear_flags_in        pulse: clears overflow_out / timeout_out
//   adc_rst_n_out         core reset, high only while converting
//   config_1_out          {10'b0, osr, avg} latched at ARM
//   config_2_out          reserved, always zero
//   adc_result_in         core result
//   adc_conv_finished_in  core completion strobe
//   result_out            FIFO head data
//   result_valid_out      FIFO not empty
//   result_ready_in       consumer accepts head
//   fifo_level_out        entries stored
//   busy_out              sequencer not idle
//   overflow_out          sticky: a result was dropped
//   timeout_out           sticky: a conversion was aborted
module adc_conversion_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_single_in,
  input  logic                        continuous_in,
  input  logic                        stop_in,
  input  logic [15:0]                 interval_in,
  input  logic [2:0]                  avg_control_in,
  input  logic [2:0]                  osr_mode_in,
  input  logic                        clear_flags_in,
  output logic                        adc_rst_n_out,
  output logic [15:0]                 config_1_out,
  output logic [15:0]                 config_2_out,
  input  logic [15:0]                 adc_result_in,
  input  logic                        adc_conv_finished_in,
  output logic [15:0]                 result_out,
  output logic                        result_valid_out,
  input  logic                        result_ready_in,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
  output logic                        busy_out,
  output logic                        overflow_out,
  output logic                        timeout_out
);

  localparam int unsigned   PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned   LW         = PW + 1;
  localparam logic [15:0]   TCNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CONVERT,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [15:0]   interval_q;
  logic          mode_cont_q;
  logic          stop_pend_q;
  logic          cont_block_q;
  logic          push_req;
  logic          timeout_evt;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_d;
  logic [15:0]   head_d;
  logic          pop, push, full, overflow_evt;

  assign config_2_out = '0;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    wcnt_d      = wcnt_q;
    push_req    = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_single_in || (continuous_in && !cont_block_q)) state_d = S_ARM;
      end
      S_ARM: begin
        tcnt_d  = '0;
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        tcnt_d = tcnt_q + 16'd1;
        if (adc_conv_finished_in) begin
          push_req = 1'b1;
          if (!mode_cont_q || stop_pend_q || stop_in || !continuous_in) begin
            state_d = S_IDLE;
          end else if (interval_q == '0) begin
            state_d = S_ARM;
          end else begin
            wcnt_d  = '0;
            state_d = S_WAIT;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          timeout_evt = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WAIT: begin
        if (stop_in || !continuous_in) begin
          state_d = S_IDLE;
        end else if (wcnt_q == interval_q - 16'd1) begin
          state_d = S_ARM;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; head_d is the head after this edge so result_out stays registered
  always_comb begin
    pop          = result_valid_out & result_ready_in;
    full         = (fifo_level_out == LEVEL_FULL);
    push         = push_req & (~full | pop);
    overflow_evt = push_req & full & ~pop;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d      = fifo_level_out;
    if (push && !pop) begin
      level_d = fifo_level_out + LW'(1);
    end else if (!push && pop) begin
      level_d = fifo_level_out - LW'(1);
    end
    head_d = result_out;
    if (level_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? adc_result_in : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= adc_result_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q           <= '0;
      wcnt_q           <= '0;
      interval_q       <= '0;
      mode_cont_q      <= 1'b0;
      stop_pend_q      <= 1'b0;
      cont_block_q     <= 1'b0;
      adc_rst_n_out    <= 1'b0;
      busy_out         <= 1'b0;
      config_1_out     <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fifo_level_out   <= '0;
      result_valid_out <= 1'b0;
      result_out       <= '0;
      overflow_out     <= 1'b0;
      timeout_out      <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      wcnt_q        <= wcnt_d;
      adc_rst_n_out <= (state_d == S_CONVERT);
      busy_out      <= (state_d != S_IDLE);

      if (state_q == S_IDLE) begin
        mode_cont_q <= continuous_in & ~start_single_in;
        stop_pend_q <= 1'b0;
      end else if ((state_q == S_ARM || state_q == S_CONVERT) && stop_in) begin
        stop_pend_q <= 1'b1;
      end

      if (state_q == S_ARM) begin
        config_1_out <= {10'b0, osr_mode_in, avg_control_in};
        interval_q   <= interval_in;
      end

      // A stop that ends a run keeps a still-high continuous_in from
      // re-arming straight out of IDLE; the block lifts once the level drops.
      if (!continuous_in) begin
        cont_block_q <= 1'b0;
      end else if (state_q != S_IDLE && state_d == S_IDLE && (stop_in || stop_pend_q)) begin
        cont_block_q <= 1'b1;
      end

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q         <= rd_ptr_d;
      fifo_level_out   <= level_d;
      result_valid_out <= (level_d != '0);
      result_out       <= head_d;

      if (overflow_evt)        overflow_out <= 1'b1;
      else if (clear_flags_in) overflow_out <= 1'b0;
      if (timeout_evt)         timeout_out  <= 1'b1;
      else if (clear_flags_in) timeout_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// tb_adc_conversion_sequencer
//   Self-checking bench for adc_conversion_sequencer. Main instance uses
//   FIFO_DEPTH=4 with the default timeout; a second instance with
//   TIMEOUT_CYCLES=16 shares all inputs and is checked in the timeout section.
module tb_adc_conversion_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_single_in, continuous_in, stop_in, clear_flags_in;
  logic [15:0] interval_in;
  logic [2:0]  avg_control_in, osr_mode_in;
  logic [15:0] adc_result_in;
  logic        adc_conv_finished_in, result_ready_in;

  logic        adc_rst_n_out, result_valid_out, busy_out, overflow_out, timeout_out;
  logic [15:0] config_1_out, config_2_out, result_out;
  logic [2:0]  fifo_level_out;

  logic        t_adc_rst_n, t_valid, t_busy, t_overflow, t_timeout;
  logic [15:0] t_cfg1, t_cfg2, t_result;
  logic [2:0]  t_level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] value;
    int          dly;
    logic [2:0]  avg;
    logic [2:0]  osr;
    logic [15:0] cfg;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  adc_conversion_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(1023)) dut (
    .clk(clk), .rst_n(rst_n), .start_single_in(start_single_in),
    .continuous_in(continuous_in), .stop_in(stop_in), .interval_in(interval_in),
    .avg_control_in(avg_control_in), .osr_mode_in(osr_mode_in),
    .clear_flags_in(clear_flags_in), .adc_rst_n_out(adc_rst_n_out),
    .config_1_out(config_1_out), .config_2_out(config_2_out),
    .adc_result_in(adc_result_in), .adc_conv_finished_in(adc_conv_finished_in),
    .result_out(result_out), .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in), .fifo_level_out(fifo_level_out),
    .busy_out(busy_out), .overflow_out(overflow_out), .timeout_out(timeout_out)
  );

  adc_conversion_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .start_single_in(start_single_in),
    .continuous_in(continuous_in), .stop_in(stop_in), .interval_in(interval_in),
    .avg_control_in(avg_control_in), .osr_mode_in(osr_mode_in),
    .clear_flags_in(clear_flags_in), .adc_rst_n_out(t_adc_rst_n),
    .config_1_out(t_cfg1), .config_2_out(t_cfg2),
    .adc_result_in(adc_result_in), .adc_conv_finished_in(adc_conv_finished_in),
    .result_out(t_result), .result_valid_out(t_valid),
    .result_ready_in(result_ready_in), .fifo_level_out(t_level),
    .busy_out(t_busy), .overflow_out(t_overflow), .timeout_out(t_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0h, expected no further result", name, result_out);
    end else begin
      check(name, result_out, sb_q.pop_front());
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    result_ready_in = 1'b1;
    while (result_valid_out && guard < 16) begin
      check_head(name);
      tick();
      guard++;
    end
    result_ready_in = 1'b0;
    check({name, "_left"}, sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic do_start();
    start_single_in = 1'b1;
    tick();
    start_single_in = 1'b0;
  endtask

  // Wait for the core reset to release, then strobe in CONVERT cycle dly.
  task automatic run_conv(input logic [15:0] val, input int dly, input bit push_exp,
                          input bit pop_with, input int stop_at,
                          output int hi, output int rise_cyc, output int last_cyc);
    int guard = 0;
    hi = 0;
    rise_cyc = -1;
    last_cyc = -1;
    while (!adc_rst_n_out && guard < 64) begin
      tick();
      guard++;
    end
    if (!adc_rst_n_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL conv_start: adc_rst_n_out %0b after %0d cycles, expected 1", adc_rst_n_out, guard);
      return;
    end
    rise_cyc = cyc;
    avg_control_in = ~avg_control_in;
    osr_mode_in    = ~osr_mode_in;
    for (int k = 1; k <= dly; k++) begin
      if (adc_rst_n_out) begin
        hi++;
        last_cyc = cyc;
      end
      stop_in = (k == stop_at);
      if (k == dly) begin
        if (pop_with) begin
          check_head("pop_with_push_head");
          result_ready_in = 1'b1;
        end
        if (push_exp) sb_q.push_back(val);
        adc_result_in        = val;
        adc_conv_finished_in = 1'b1;
      end
      tick();
    end
    adc_conv_finished_in = 1'b0;
    stop_in              = 1'b0;
    result_ready_in      = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int hi, rise, last, prev_last, t0, rises;
    vecs[0] = '{16'h0A5C, 20, 3'd2, 3'd5, 16'h002A};
    vecs[1] = '{16'hFFFF,  1, 3'd7, 3'd0, 16'h0007};
    vecs[2] = '{16'h0000,  5, 3'd0, 3'd7, 16'h0038};
    vecs[3] = '{16'h1234,  3, 3'd1, 3'd1, 16'h0009};

    start_single_in = 0; continuous_in = 0; stop_in = 0; clear_flags_in = 0;
    interval_in = '0; avg_control_in = '0; osr_mode_in = '0;
    adc_result_in = '0; adc_conv_finished_in = 0; result_ready_in = 0;
    do_reset();

    check("reset_adc_rst_n", adc_rst_n_out, 0);
    check("reset_config_1", config_1_out, 0);
    check("reset_config_2", config_2_out, 0);
    check("reset_result", result_out, 0);
    check("reset_valid", result_valid_out, 0);
    check("reset_level", fifo_level_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_overflow", overflow_out, 0);
    check("reset_timeout", timeout_out, 0);

    // Single shots from the vector table
    for (int i = 0; i < 4; i++) begin
      avg_control_in = vecs[i].avg;
      osr_mode_in    = vecs[i].osr;
      t0 = cyc;
      do_start();
      check("single_arm_busy", busy_out, 1);
      check("single_arm_rst", adc_rst_n_out, 0);
      run_conv(vecs[i].value, vecs[i].dly, 1, 0, 0, hi, rise, last);
      check("single_latency", rise - t0, 2);
      check("single_hi_cycles", hi, vecs[i].dly);
      check("single_rst_low", adc_rst_n_out, 0);
      check("single_valid", result_valid_out, 1);
      check("single_level", fifo_level_out, 1);
      check("single_busy_end", busy_out, 0);
      check("single_config", config_1_out, vecs[i].cfg);
      drain("single_result");
    end

    // Continuous, interval 3, strobe 10 cycles into each CONVERT
    do_reset();
    interval_in   = 16'd3;
    continuous_in = 1'b1;
    prev_last = 0;
    for (int c = 0; c < 4; c++) begin
      run_conv(16'h4000 | 16'(c), 10, 1, 0, 0, hi, rise, last);
      check("cont_hi_cycles", hi, 10);
      if (c > 0) check("cont_spacing", rise - prev_last, 5);
      prev_last = last;
    end
    check("cont_wait_busy", busy_out, 1);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("cont_stop_busy", busy_out, 0);
    rises = 0;
    for (int k = 0; k < 20; k++) begin
      if (adc_rst_n_out) rises++;
      tick();
    end
    check("cont_no_rearm", rises, 0);
    check("cont_level", fifo_level_out, 4);
    check("cont_overflow", overflow_out, 0);
    continuous_in = 1'b0;
    tick();
    drain("cont_result");

    // Stop mid-conversion
    do_reset();
    interval_in   = 16'd2;
    continuous_in = 1'b1;
    run_conv(16'hBEEF, 12, 1, 0, 5, hi, rise, last);
    check("stopmid_hi_cycles", hi, 12);
    check("stopmid_busy", busy_out, 0);
    check("stopmid_level", fifo_level_out, 1);
    rises = 0;
    for (int k = 0; k < 20; k++) begin
      if (adc_rst_n_out) rises++;
      tick();
    end
    check("stopmid_no_rearm", rises, 0);
    continuous_in = 1'b0;
    tick();
    drain("stopmid_result");

    // Overflow: five conversions into a four-entry FIFO, no consumer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_start();
      run_conv(16'hC000 | 16'(i), 4, i < 4, 0, 0, hi, rise, last);
    end
    check("ovf_level", fifo_level_out, 4);
    check("ovf_flag", overflow_out, 1);
    check("ovf_head", result_out, 16'hC000);
    drain("ovf_order");
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    check("ovf_cleared", overflow_out, 0);

    // Full FIFO with a pop coincident with the fifth push
    for (int i = 0; i < 5; i++) begin
      do_start();
      run_conv(16'hD000 | 16'(i), 4, 1, i == 4, 0, hi, rise, last);
    end
    check("fullpop_level", fifo_level_out, 4);
    check("fullpop_overflow", overflow_out, 0);
    drain("fullpop_order");

    // Timeout on the TIMEOUT_CYCLES=16 instance
    do_reset();
    do_start();
    run_conv(16'h7777, 5, 1, 0, 0, hi, rise, last);
    check("to_pre_level", t_level, 1);
    do_start();
    tick();
    hi = 0;
    for (int k = 1; k <= 20; k++) begin
      if (t_adc_rst_n) hi++;
      clear_flags_in = (k == 16);
      tick();
    end
    clear_flags_in = 1'b0;
    check("to_hi_cycles", hi, 16);
    check("to_flag_set_wins", t_timeout, 1);
    check("to_rst_low", t_adc_rst_n, 0);
    check("to_busy", t_busy, 0);
    check("to_level", t_level, 1);
    check("to_head", t_result, 16'h7777);
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    check("to_cleared", t_timeout, 0);
    do_start();
    tick();
    hi = 0;
    for (int k = 1; k <= 16; k++) begin
      if (t_adc_rst_n) hi++;
      if (k == 16) begin
        adc_result_in        = 16'h5A5A;
        adc_conv_finished_in = 1'b1;
        sb_q.push_back(16'h5A5A);
      end
      tick();
    end
    adc_conv_finished_in = 1'b0;
    check("to_edge_hi_cycles", hi, 16);
    check("to_edge_no_flag", t_timeout, 0);
    check("to_edge_level", t_level, 2);
    check("main_ignored_start_level", fifo_level_out, 2);
    drain("main_after_timeout");

    // Reset mid-conversion with two results buffered
    do_reset();
    do_start();
    run_conv(16'h1111, 3, 1, 0, 0, hi, rise, last);
    do_start();
    run_conv(16'h2222, 3, 1, 0, 0, hi, rise, last);
    check("rstmid_pre_level", fifo_level_out, 2);
    do_start();
    tick();
    tick();
    check("rstmid_in_convert", adc_rst_n_out, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    check("rstmid_adc_rst", adc_rst_n_out, 0);
    check("rstmid_level", fifo_level_out, 0);
    check("rstmid_valid", result_valid_out, 0);
    check("rstmid_result", result_out, 0);
    check("rstmid_busy", busy_out, 0);
    check("rstmid_flags", {overflow_out, timeout_out}, 0);
    tick();
    tick();
    check("rstmid_stays_idle", busy_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
